melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Sequences the square-wave note player through a programmable melody.
//  Holds DEPTH (period, duration) entries and plays entries 0..len-1 in order.
//  For each note it drives the player's period and rst inputs, with optional
//  looping. Sits between the user/config logic and the note player instance.
// PARAMETERS
//  DEPTH     8  number of melody entries (power of 2); AW = $clog2(DEPTH)
//  PERIOD_W  8  width of period field, matches note player period port
//  DUR_W     8  width of duration field, in clock cycles
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous, active-high reset
//  wr_en      in   1         write melody entry this cycle
//  wr_addr    in   AW        entry index to write
//  wr_period  in   PERIOD_W  period of entry; 0 = rest (silence)
//  wr_dur     in   DUR_W     duration of entry in cycles; 0 treated as 1
//  len        in   AW+1      number of entries to play (0..DEPTH)
//  loop       in   1         1 = restart at entry 0 after last entry
//  start      in   1         begin playback (sampled in IDLE only)
//  stop       in   1         abort playback
//  np_rst     out  1         drives note player rst
//  np_period  out  PERIOD_W  drives note player period (registered)
//  idx        out  AW        entry currently loaded/playing
//  busy       out  1         1 in LOAD or PLAY
//  done       out  1         one-cycle pulse when melody completes
//  state      out  4         one-hot FSM state for debug
// BEHAVIOUR
//  - States: IDLE=4'b0000, LOAD=4'b1000, PLAY=4'b0100, DONE=4'b0010.
//  - Reset: state=IDLE, idx=0, np_period=0, np_rst=1, busy=0, done=0, count=0.
//    Reset has priority over every other input, including mid-note.
//  - IDLE: start & len!=0 -> LOAD, idx=0. start & len==0 -> DONE. Otherwise
//    stay in IDLE.
//  - LOAD (1 cycle): latch np_period<=mem[idx].period and
//    count<=max(mem[idx].dur,1); -> PLAY.
//  - PLAY: count decrements each cycle. When count==1:
//    - if idx==len-1: loop -> LOAD with idx=0; !loop -> DONE.
//    - else -> LOAD with idx+1.
//    Each note therefore occupies 1 LOAD cycle + max(dur,1) PLAY cycles.
//  - DONE (1 cycle): done=1; -> IDLE. done is 0 in all other states.
//  - np_rst=1 in IDLE, LOAD and DONE, and in PLAY when np_period==0 (rest).
//    np_rst=0 in PLAY otherwise. The player restarts cleanly on every note.
//  - stop: in LOAD/PLAY -> IDLE next cycle, idx=0, no done pulse.
//    stop has priority over count expiry. stop in IDLE is ignored;
//    stop with start in IDLE -> stay in IDLE.
//  - start in LOAD/PLAY/DONE is ignored.
//  - len and loop are sampled live. If len is lowered below idx+1 during play,
//    the melody ends at the next note boundary (idx>=len-1 compare) -> DONE
//    or loop.
//  - Writes are accepted in any state, at the clock edge. A LOAD in the same
//    cycle as a write to mem[idx] reads the old value. The note being played
//    is unaffected by later writes (already latched).
//  - idx wraps only via the loop path; it never exceeds DEPTH-1.
// STRUCTURE
//  - Shared package: state encodings (IDLE/LOAD/PLAY/DONE) and PERIOD_W
//    default, shared with the note player bench.
//  - Sub-module melody_mem: DEPTH x (PERIOD_W+DUR_W) register file, one sync
//    write port and one combinational read port (raddr=idx).
//  - Top level: FSM, duration down-counter, idx counter, np_period register.
// TESTING
//  1. Write {p=3,d=4},{p=5,d=2}; len=2, loop=0, start -> idx 0: 1 LOAD + 4
//     PLAY cycles, np_period=3; idx 1: 1 LOAD + 2 PLAY cycles, np_period=5;
//     done pulse; IDLE.
//  2. len=1, loop=1, entry {p=2,d=3}, start -> LOAD,PLAY x3 repeating, np_rst
//     high only in LOAD, done never asserted.
//  3. Entry {p=0,d=2} (rest) -> np_rst=1 for all 3 cycles of the note;
//     entry {p=4,d=0} -> exactly 1 PLAY cycle.
//  4. stop during 2nd PLAY cycle -> IDLE next cycle, np_rst=1, idx=0, done=0;
//     rst mid-PLAY -> IDLE and all reset values.
//  5. Write mem[0] in the same cycle as LOAD of idx 0 -> old period latched;
//     the new value plays on the next loop pass.
//  6. start with len=0 -> DONE one cycle (done=1), then IDLE; start during
//     PLAY -> ignored, sequence unchanged.

Source files
------------

// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: one-hot state encodings and the
// default period width shared with the note player.
package melody_sequencer_pkg;

  localparam int unsigned PeriodWDefault = 8;

  typedef enum logic [3:0] {
    StIdle = 4'b0000,
    StLoad = 4'b1000,
    StPlay = 4'b0100,
    StDone = 4'b0010
  } state_e;

  function automatic logic state_busy(input state_e s);
    return (s == StLoad) || (s == StPlay);
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Config/control bus between user logic (master) and the melody sequencer (slave),
// including the note player drive outputs and debug state.
interface melody_sequencer_if
  import melody_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PERIOD_W = PeriodWDefault,
  parameter int unsigned DUR_W    = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [PERIOD_W-1:0] wr_period;
  logic [DUR_W-1:0]    wr_dur;
  logic [AW:0]         len;
  logic                loop;
  logic                start;
  logic                stop;
  logic                np_rst;
  logic [PERIOD_W-1:0] np_period;
  logic [AW-1:0]       idx;
  logic                busy;
  logic                done;
  logic [3:0]          state;

  modport master (
    output wr_en, wr_addr, wr_period, wr_dur, len, loop, start, stop,
    input  np_rst, np_period, idx, busy, done, state
  );

  modport slave (
    input  wr_en, wr_addr, wr_period, wr_dur, len, loop, start, stop,
    output np_rst, np_period, idx, busy, done, state
  );

endinterface

// File: rtl/melody_sequencer_mem.sv
// Melody entry register file: one synchronous write port, one combinational read
// port. Contents are not reset; the melody is expected to be programmed before use.
module melody_sequencer_mem #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned DUR_W    = 8,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [PERIOD_W-1:0] i_wr_period,
  input  logic [DUR_W-1:0]    i_wr_dur,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [PERIOD_W-1:0] o_rd_period,
  output logic [DUR_W-1:0]    o_rd_dur
);

  logic [PERIOD_W+DUR_W-1:0] r_mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem_q[i_wr_addr] <= {i_wr_period, i_wr_dur};
    end
  end

  // Read-before-write: a same-cycle write is only visible from the next cycle.
  assign {o_rd_period, o_rd_dur} = r_mem_q[i_rd_addr];

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through programmed (period, duration) entries and drives
// the note player's period and reset, with optional looping.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PERIOD_W = PeriodWDefault,
  parameter int unsigned DUR_W    = 8
) (
  input logic              clk,
  input logic              rst,
  melody_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e              r_state_q, w_state_d;
  logic [AW-1:0]       r_idx_q, w_idx_d;
  logic [DUR_W-1:0]    r_count_q, w_count_d;
  logic [PERIOD_W-1:0] r_period_q, w_period_d;
  logic [PERIOD_W-1:0] w_rd_period;
  logic [DUR_W-1:0]    w_rd_dur;
  logic                w_last;

  melody_sequencer_mem #(
    .DEPTH    (DEPTH),
    .PERIOD_W (PERIOD_W),
    .DUR_W    (DUR_W)
  ) u_mem (
    .i_clk       (clk),
    .i_wr_en     (bus.wr_en),
    .i_wr_addr   (bus.wr_addr),
    .i_wr_period (bus.wr_period),
    .i_wr_dur    (bus.wr_dur),
    .i_rd_addr   (r_idx_q),
    .o_rd_period (w_rd_period),
    .o_rd_dur    (w_rd_dur)
  );

  // idx+1 >= len also ends the melody when len is lowered below the current entry.
  assign w_last = ({1'b0, r_idx_q} + (AW+1)'(1)) >= bus.len;

  always_comb begin
    w_state_d  = r_state_q;
    w_idx_d    = r_idx_q;
    w_count_d  = r_count_q;
    w_period_d = r_period_q;
    unique case (r_state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          w_idx_d   = '0;
          w_state_d = (bus.len != '0) ? StLoad : StDone;
        end
      end
      StLoad: begin
        if (bus.stop) begin
          w_state_d = StIdle;
          w_idx_d   = '0;
        end else begin
          w_period_d = w_rd_period;
          w_count_d  = (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;
          w_state_d  = StPlay;
        end
      end
      StPlay: begin
        if (bus.stop) begin
          w_state_d = StIdle;
          w_idx_d   = '0;
        end else if (r_count_q <= DUR_W'(1)) begin
          if (!w_last) begin
            w_idx_d   = r_idx_q + AW'(1);
            w_state_d = StLoad;
          end else if (bus.loop) begin
            w_idx_d   = '0;
            w_state_d = StLoad;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_count_d = r_count_q - DUR_W'(1);
        end
      end
      StDone: w_state_d = StIdle;
      default: begin
        w_state_d = StIdle;
        w_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= StIdle;
      r_idx_q    <= '0;
      r_count_q  <= '0;
      r_period_q <= '0;
    end else begin
      r_state_q  <= w_state_d;
      r_idx_q    <= w_idx_d;
      r_count_q  <= w_count_d;
      r_period_q <= w_period_d;
    end
  end

  // A zero period is a rest: keep the player in reset for the whole note.
  assign bus.np_rst    = !((r_state_q == StPlay) && (r_period_q != '0));
  assign bus.np_period = r_period_q;
  assign bus.idx       = r_idx_q;
  assign bus.busy      = state_busy(r_state_q);
  assign bus.done      = (r_state_q == StDone);
  assign bus.state     = r_state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: hand-computed per-cycle expectations for
// playback, looping, rests, stop/reset, write-during-load and start corner cases.
module tb_melody_sequencer;

  localparam logic [3:0] SI = 4'b0000;
  localparam logic [3:0] SL = 4'b1000;
  localparam logic [3:0] SP = 4'b0100;
  localparam logic [3:0] SD = 4'b0010;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  melody_sequencer_if #(.DEPTH(8), .PERIOD_W(8), .DUR_W(8)) bus ();

  melody_sequencer #(.DEPTH(8), .PERIOD_W(8), .DUR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exp_cyc(input string tag, input logic [3:0] st, input logic [2:0] ix,
                         input logic [7:0] per, input logic nr, input logic dn);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".idx"}, 32'(bus.idx), 32'(ix));
    check({tag, ".np_period"}, 32'(bus.np_period), 32'(per));
    check({tag, ".np_rst"}, 32'(bus.np_rst), 32'(nr));
    check({tag, ".done"}, 32'(bus.done), 32'(dn));
    check({tag, ".busy"}, 32'(bus.busy), 32'((st == SL) || (st == SP)));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = a;
    bus.wr_period = p;
    bus.wr_dur    = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_period = '0;
    bus.wr_dur    = '0;
    bus.len       = '0;
    bus.loop      = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    tick();
    tick();
    exp_cyc("reset", SI, 3'd0, 8'd0, 1'b1, 1'b0);
    rst = 1'b0;

    // 1: two-note melody, no loop
    wr(3'd0, 8'd3, 8'd4);
    wr(3'd1, 8'd5, 8'd2);
    bus.len   = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t1.load0", SL, 3'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_cyc($sformatf("t1.play0_%0d", i), SP, 3'd0, 8'd3, 1'b0, 1'b0);
    end
    tick();
    exp_cyc("t1.load1", SL, 3'd1, 8'd3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_cyc($sformatf("t1.play1_%0d", i), SP, 3'd1, 8'd5, 1'b0, 1'b0);
    end
    tick();
    exp_cyc("t1.done", SD, 3'd1, 8'd5, 1'b1, 1'b1);
    tick();
    exp_cyc("t1.idle", SI, 3'd1, 8'd5, 1'b1, 1'b0);

    // 2: single looping note; stop lands in LOAD
    wr(3'd0, 8'd2, 8'd3);
    bus.len   = 4'd1;
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t2.load_first", SL, 3'd0, 8'd5, 1'b1, 1'b0);
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        exp_cyc($sformatf("t2.play_p%0d_%0d", pass, i), SP, 3'd0, 8'd2, 1'b0, 1'b0);
      end
      tick();
      exp_cyc($sformatf("t2.reload_p%0d", pass), SL, 3'd0, 8'd2, 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    exp_cyc("t2.stop_in_load", SI, 3'd0, 8'd2, 1'b1, 1'b0);

    // 3: rest note then zero-duration note
    wr(3'd0, 8'd0, 8'd2);
    wr(3'd1, 8'd4, 8'd0);
    bus.len   = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t3.load0", SL, 3'd0, 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_cyc($sformatf("t3.rest_%0d", i), SP, 3'd0, 8'd0, 1'b1, 1'b0);
    end
    tick();
    exp_cyc("t3.load1", SL, 3'd1, 8'd0, 1'b1, 1'b0);
    tick();
    exp_cyc("t3.play_dur0", SP, 3'd1, 8'd4, 1'b0, 1'b0);
    tick();
    exp_cyc("t3.done", SD, 3'd1, 8'd4, 1'b1, 1'b1);
    tick();
    exp_cyc("t3.idle", SI, 3'd1, 8'd4, 1'b1, 1'b0);

    // 4: stop in 2nd PLAY cycle, reset mid-PLAY, stop+start in IDLE
    wr(3'd0, 8'd3, 8'd4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t4.load0", SL, 3'd0, 8'd4, 1'b1, 1'b0);
    tick();
    exp_cyc("t4.play_a", SP, 3'd0, 8'd3, 1'b0, 1'b0);
    tick();
    exp_cyc("t4.play_b", SP, 3'd0, 8'd3, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp_cyc("t4.stopped", SI, 3'd0, 8'd3, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    exp_cyc("t4.play_pre_rst", SP, 3'd0, 8'd3, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cyc("t4.rst_mid_play", SI, 3'd0, 8'd0, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    exp_cyc("t4.start_stop_idle", SI, 3'd0, 8'd0, 1'b1, 1'b0);

    // 5: write mem[0] during LOAD of idx 0; new value plays next pass
    wr(3'd0, 8'd6, 8'd1);
    bus.len   = 4'd1;
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t5.load", SL, 3'd0, 8'd0, 1'b1, 1'b0);
    wr(3'd0, 8'd7, 8'd1);
    exp_cyc("t5.play_old", SP, 3'd0, 8'd6, 1'b0, 1'b0);
    tick();
    exp_cyc("t5.reload", SL, 3'd0, 8'd6, 1'b1, 1'b0);
    tick();
    exp_cyc("t5.play_new", SP, 3'd0, 8'd7, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    exp_cyc("t5.stopped", SI, 3'd0, 8'd7, 1'b1, 1'b0);

    // 6: start with len=0, then start held during PLAY
    bus.len   = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_cyc("t6.len0_done", SD, 3'd0, 8'd7, 1'b1, 1'b1);
    tick();
    exp_cyc("t6.len0_idle", SI, 3'd0, 8'd7, 1'b1, 1'b0);
    wr(3'd0, 8'd9, 8'd3);
    bus.len   = 4'd1;
    bus.start = 1'b1;
    tick();
    exp_cyc("t6.load", SL, 3'd0, 8'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cyc($sformatf("t6.play_%0d", i), SP, 3'd0, 8'd9, 1'b0, 1'b0);
    end
    bus.start = 1'b0;
    tick();
    exp_cyc("t6.done", SD, 3'd0, 8'd9, 1'b1, 1'b1);
    tick();
    exp_cyc("t6.idle", SI, 3'd0, 8'd9, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
